hazard_ctrl: RTL and testbench

Pipeline hazard controller that consumes the EX-stage outputs of the ID/EX register and the ID-stage source-register fields, and drives stall, flush and bubble controls back into PC, IF/ID and ID/EX. It resolves load-use hazards, taken branches and jumps, and multi-cycle EX operations. It is the consumer/controller end of the ID/EX register interface. It sits beside the pipeline registers in the processor top level.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_cmp.sv | 35 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard controller and its
// load-use compare.
//   state_t  : controller FSM encoding (RUN, MC_WAIT, FLUSH)
//   MEM_LOAD : EX memory-control code for a load
//   REG_ZERO : hard-wired zero register, never a hazard source
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// hazard_cmp
// Combinational load-use compare: flags when the instruction in EX is a
// register-writing load whose destination is read by the instruction in ID.
// Ports:
//   id_rs, id_rt            in  ID source register fields
//   id_uses_rs, id_uses_rt  in  ID instruction reads that field
//   ex_Mem_Write_Read       in  EX memory control (MEM_LOAD = load)
//   ex_RegWrite             in  EX writes the register file
//   ex_dest                 in  EX destination register
//   hazard                  out load-use hazard present
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [1:0] ex_Mem_Write_Read,
  input  logic       ex_RegWrite,
  input  logic [4:0] ex_dest,
  output logic       hazard
);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // Writes to the zero register are discarded, so they can never feed ID.
  assign ex_is_load = (ex_Mem_Write_Read == MEM_LOAD) && ex_RegWrite &&
                      (ex_dest != REG_ZERO);
  assign rs_match   = id_uses_rs && (id_rs == ex_dest);
  assign rt_match   = id_uses_rt && (id_rt == ex_dest);
  assign hazard     = ex_is_load && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller. Looks at the EX-stage controls of the ID/EX
// register and the ID source fields, and drives stall/flush/bubble controls
// into PC, IF/ID and ID/EX for load-use hazards, redirects (taken branch or
// jump) and multi-cycle EX operations.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | normal flow; resolve redirect > multi-cycle > load-use
//   MC_WAIT | multi-cycle op occupying EX; hold front end and ID/EX
//   FLUSH   | extra IF/ID flush cycle after a redirect
//
// Parameters:
//   MC_CYCLES   total EX occupancy of a multi-cycle op (2..16)
//   FLUSH_EXTRA extra IF/ID flush cycles after a redirect (0 or 1)
// Ports:
//   clk, rst                  pipeline clock, synchronous active-high reset
//   id_rs/id_rt, id_uses_*    ID source fields and their read enables
//   ex_Mem_Write_Read, ex_RegWrite, ex_dest   EX load detection
//   ex_branch_taken, ex_jump  EX redirect sources
//   ex_mc_start               EX holds a new multi-cycle op
//   pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold  controls
//   busy                      FSM not in RUN
// Optional feature (macro HAZARD_PERF_CNT_EN): adds 32-bit stall_cnt and
// flush_cnt performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_CYCLES   = 4,
  parameter int FLUSH_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [1:0]  ex_Mem_Write_Read,
  input  logic        ex_RegWrite,
  input  logic [4:0]  ex_dest,
  input  logic        ex_branch_taken,
  input  logic [1:0]  ex_jump,
  input  logic        ex_mc_start,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_hold,
  output logic        busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // The start cycle is spent in RUN, so MC_WAIT covers the remaining
  // MC_CYCLES-1 cycles: counter loaded with MC_CYCLES-2, exit at zero.
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 2);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       load_use;
  logic       redirect;

  hazard_cmp u_cmp (
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_Mem_Write_Read (ex_Mem_Write_Read),
    .ex_RegWrite       (ex_RegWrite),
    .ex_dest           (ex_dest),
    .hazard            (load_use)
  );

  assign redirect = ex_branch_taken || (ex_jump != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    busy        = 1'b0;
    // Reset is synchronous but must silence the controls in its own cycle.
    if (!rst) begin
      busy = (state != RUN);
      case (state)
        RUN: begin
          // A redirect squashes the ID instruction, so any load-use stall
          // or multi-cycle start seen alongside it is moot.
          if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = (FLUSH_EXTRA == 1) ? FLUSH : RUN;
          end else if (ex_mc_start) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_hold  = 1'b1;
            cnt_nxt    = MC_LOAD;
            state_nxt  = MC_WAIT;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MC_WAIT: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_hold  = 1'b1;
          if (cnt == 4'd0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          state_nxt  = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_stall)   stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MC_CYCLES   = 4;
  localparam int FLUSH_EXTRA = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       id_uses_rs, id_uses_rt, ex_RegWrite, ex_branch_taken, ex_mc_start;
  logic [1:0] ex_Mem_Write_Read, ex_jump;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_CYCLES(MC_CYCLES), .FLUSH_EXTRA(FLUSH_EXTRA)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_Mem_Write_Read (ex_Mem_Write_Read),
    .ex_RegWrite       (ex_RegWrite),
    .ex_dest           (ex_dest),
    .ex_branch_taken   (ex_branch_taken),
    .ex_jump           (ex_jump),
    .ex_mc_start       (ex_mc_start),
    .pc_stall          (pc_stall),
    .ifid_stall        (ifid_stall),
    .ifid_flush        (ifid_flush),
    .idex_bubble       (idex_bubble),
    .idex_hold         (idex_hold),
    .busy              (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
`endif
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold, busy}
  typedef struct {
    logic [5:0] ctl;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: remaining occupancy cycles after the current one.
  int          mc_left = 0;
  int          fl_left = 0;
  logic [31:0] m_stall_cnt = 0;
  logic [31:0] m_flush_cnt = 0;

  function automatic logic [5:0] model_step(
    input logic r, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic [1:0] mwr, input logic rw,
    input logic [4:0] dst, input logic br, input logic [1:0] jmp, input logic mc);
    logic st, fl, bub, hld, bsy, lu;
    st = 0; fl = 0; bub = 0; hld = 0; bsy = 0;
    lu = (mwr == 2'b01) && rw && (dst != 0) &&
         ((urs && rs == dst) || (urt && rt == dst));
    if (r) begin
      mc_left = 0;
      fl_left = 0;
    end else if (mc_left > 0) begin
      st = 1; hld = 1; bsy = 1;
      mc_left--;
    end else if (fl_left > 0) begin
      fl = 1; bsy = 1;
      fl_left--;
    end else if (br || jmp != 0) begin
      fl = 1; bub = 1;
      fl_left = FLUSH_EXTRA;
    end else if (mc) begin
      st = 1; hld = 1;
      mc_left = MC_CYCLES - 1;
    end else if (lu) begin
      st = 1; bub = 1;
    end
    if (r) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      m_stall_cnt += st ? 1 : 0;
      m_flush_cnt += fl ? 1 : 0;
    end
    return {st, st, fl, bub, hld, bsy};
  endfunction

  task automatic drive(
    input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic [1:0] mwr, input logic rw,
    input logic [4:0] dst, input logic br, input logic [1:0] jmp, input logic mc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_Mem_Write_Read = mwr; ex_RegWrite = rw; ex_dest = dst;
    ex_branch_taken = br; ex_jump = jmp; ex_mc_start = mc;
    e.ctl = model_step(r, rs, rt, urs, urt, mwr, rw, dst, br, jmp, mc);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++)
      drive(tag, 0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold, busy};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL %s: got stall/ifst/flush/bub/hold/busy=%b expected %b at %0t",
                   e.tag, act, e.ctl, $time);
        end
        checks++;
        if (idex_bubble && idex_hold) begin
          failures++;
          $display("FAIL exclusive_%s: bubble=%b hold=%b expected not both", e.tag,
                   idex_bubble, idex_hold);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rs, rt, dst;
    logic       r;
    logic [1:0] jmp, mwr;
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_Mem_Write_Read = 0; ex_RegWrite = 0; ex_dest = 0;
    ex_branch_taken = 0; ex_jump = 0; ex_mc_start = 0;

    drive("reset", 1, 5'd5, 5'd5, 1, 1, 2'b01, 1, 5'd5, 1, 2'b01, 1);
    drive("reset", 1, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 0);

    drive("load_use_rs", 0, 5'd5, 5'd3, 1, 0, 2'b01, 1, 5'd5, 0, 2'b00, 0);
    idle("load_use_after", 1);
    drive("reg_zero", 0, 5'd0, 5'd0, 1, 1, 2'b01, 1, 5'd0, 0, 2'b00, 0);
    drive("no_read", 0, 5'd5, 5'd7, 0, 1, 2'b01, 1, 5'd5, 0, 2'b00, 0);
    drive("load_use_rt", 0, 5'd1, 5'd9, 1, 1, 2'b01, 1, 5'd9, 0, 2'b00, 0);
    drive("store_no_hz", 0, 5'd9, 5'd9, 1, 1, 2'b10, 1, 5'd9, 0, 2'b00, 0);
    drive("no_regwrite", 0, 5'd9, 5'd9, 1, 1, 2'b01, 0, 5'd9, 0, 2'b00, 0);

    drive("reset", 1, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 0);
    drive("mc_start", 0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 1);
    drive("mc_wait", 0, 5'd4, 5'd0, 1, 0, 2'b01, 1, 5'd4, 1, 2'b00, 1);
    idle("mc_wait", 2);
    idle("mc_done", 2);
`ifdef HAZARD_PERF_CNT_EN
    #1;
    checks++;
    if (stall_cnt !== 32'd4) begin
      failures++;
      $display("FAIL perf_stall_mc: got %0d expected 4", stall_cnt);
    end
`endif

    drive("br_lu", 0, 5'd6, 5'd0, 1, 0, 2'b01, 1, 5'd6, 1, 2'b00, 0);
    drive("flush_extra", 0, 5'd6, 5'd0, 1, 0, 2'b01, 1, 5'd6, 1, 2'b00, 0);
    idle("after_flush", 1);
    drive("jump_mc", 0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b10, 1);
    idle("after_jump", 2);

    drive("mc_start2", 0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 1);
    idle("mc_wait1", 1);
    drive("rst_mid_wait", 1, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 0);
    idle("post_rst", 2);
    drive("br_only", 0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 2'b00, 0);
    drive("rst_mid_flush", 1, 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 2'b00, 0);
    idle("post_rst2", 1);

    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      dst = 5'($urandom_range(0, 7));
      mwr = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom);
      jmp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive("random", r, rs, rt, 1'($urandom), 1'($urandom), mwr, 1'($urandom),
            dst, ($urandom_range(0, 9) == 0), jmp, ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== m_stall_cnt) begin
      failures++;
      $display("FAIL perf_stall_end: got %0d expected %0d", stall_cnt, m_stall_cnt);
    end
    checks++;
    if (flush_cnt !== m_flush_cnt) begin
      failures++;
      $display("FAIL perf_flush_end: got %0d expected %0d", flush_cnt, m_flush_cnt);
    end
`endif
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
